// File: rtl/playfield_ctrl.sv
// rtl/playfield_ctrl.sv - wave profile RAM fill sequencer with player position control
//
// Purpose: on a mode change or start request, waits for a vsync rising edge and then
// writes DEPTH consecutive profile samples (flat/ramp/triangle) to an external RAM.
// Independently tracks a player's vertical position from up/down button edges.
//
// Ports:
//   clock, reset_n        : clock, synchronous active-low reset
//   mode[1:0]             : profile select (0 flat, 1 ramp, 2 triangle, 3 flat)
//   start                 : one-cycle refill request
//   vsync                 : vertical sync, active high
//   up, down              : debounced button levels
//   wave_we/index/data    : profile RAM write port
//   busy                  : fill pending or in progress
//   done                  : one-cycle pulse on fill completion
//   p_vpos                : player vertical position
module playfield_ctrl #(
    parameter int DEPTH    = 1024,
    parameter int WAVE_W   = 10,
    parameter int IDX_W    = 10,
    parameter int VMAX     = 767,
    parameter int LEVEL    = 384,
    parameter int STEP     = 100,
    parameter int TRI_HALF = 256
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic              vsync,
    input  logic              up,
    input  logic              down,
    output logic              wave_we,
    output logic [IDX_W-1:0]  wave_index,
    output logic [WAVE_W-1:0] wave_data,
    output logic              busy,
    output logic              done,
    output logic [WAVE_W-1:0] p_vpos
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_VS = 2'd1;
    localparam logic [1:0] S_FILL    = 2'd2;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [WAVE_W-1:0] LEVEL_V  = WAVE_W'(LEVEL);
    localparam logic [WAVE_W-1:0] STEP_V   = WAVE_W'(STEP);
    localparam logic [WAVE_W-1:0] VMAX_V   = WAVE_W'(VMAX);
    localparam logic [WAVE_W:0]   STEP_X   = (WAVE_W + 1)'(STEP);
    localparam logic [WAVE_W:0]   VMAX_X   = (WAVE_W + 1)'(VMAX);

    // Profile sample for index i; modulo by constants only.
    function automatic logic [WAVE_W-1:0] wave_val(input logic [1:0] m, input logic [IDX_W-1:0] i);
        logic [31:0] ii;
        logic [31:0] t;
        logic [31:0] r;
        ii = 32'(i);
        t  = ii % (2 * TRI_HALF);
        case (m)
            2'd1:    r = ii % (VMAX + 1);
            2'd2:    r = (t < TRI_HALF) ? t : (2 * TRI_HALF - 1 - t);
            default: r = LEVEL;
        endcase
        return r[WAVE_W-1:0];
    endfunction

    logic [1:0]        state_q, state_d;
    logic [1:0]        cur_mode_q;
    logic [1:0]        fill_mode_q, fill_mode_d;
    logic              vsync_q;
    logic              we_q, we_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WAVE_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              up_q, down_q;
    logic [WAVE_W-1:0] p_q, p_d;

    logic              vs_rise;
    logic              up_rise;
    logic              down_rise;
    logic [IDX_W-1:0]  idx_nxt;
    logic [WAVE_W:0]   p_sum;

    assign vs_rise   = vsync & ~vsync_q;
    assign up_rise   = up & ~up_q;
    assign down_rise = down & ~down_q;
    assign idx_nxt   = idx_q + IDX_W'(1);
    assign p_sum     = {1'b0, p_q} + STEP_X;

    always_comb begin
        state_d     = state_q;
        fill_mode_d = fill_mode_q;
        we_d        = 1'b0;
        idx_d       = idx_q;
        data_d      = data_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((mode != cur_mode_q) || start) begin
                    state_d = S_WAIT_VS;
                end
            end
            S_WAIT_VS: begin
                // First write is issued from here so FILL starts with index 0 valid.
                if (vs_rise) begin
                    state_d     = S_FILL;
                    fill_mode_d = mode;
                    we_d        = 1'b1;
                    idx_d       = '0;
                    data_d      = wave_val(mode, '0);
                end
            end
            S_FILL: begin
                // A mode change outranks completion, even on the last write.
                if (mode != cur_mode_q) begin
                    state_d = S_WAIT_VS;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    we_d   = 1'b1;
                    idx_d  = idx_nxt;
                    data_d = wave_val(fill_mode_q, idx_nxt);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        p_d = p_q;
        if (up_rise && !down_rise) begin
            p_d = (p_q >= STEP_V) ? (p_q - STEP_V) : '0;
        end else if (down_rise && !up_rise) begin
            p_d = (p_sum <= VMAX_X) ? p_sum[WAVE_W-1:0] : VMAX_V;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            // Edge detectors preset high so levels held through reset do not fire.
            state_q     <= S_WAIT_VS;
            cur_mode_q  <= mode;
            fill_mode_q <= mode;
            vsync_q     <= 1'b1;
            we_q        <= 1'b0;
            idx_q       <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            up_q        <= 1'b1;
            down_q      <= 1'b1;
            p_q         <= LEVEL_V;
        end else begin
            state_q     <= state_d;
            cur_mode_q  <= mode;
            fill_mode_q <= fill_mode_d;
            vsync_q     <= vsync;
            we_q        <= we_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            done_q      <= done_d;
            up_q        <= up;
            down_q      <= down;
            p_q         <= p_d;
        end
    end

    assign wave_we    = we_q;
    assign wave_index = idx_q;
    assign wave_data  = data_q;
    assign done       = done_q;
    assign busy       = (state_q == S_WAIT_VS) || (state_q == S_FILL);
    assign p_vpos     = p_q;

endmodule

// File: tb/tb_playfield_ctrl.sv
// tb/tb_playfield_ctrl.sv - self-checking bench for playfield_ctrl
module tb_playfield_ctrl;

    logic       clock;
    logic       reset_n;
    logic [1:0] mode;
    logic       start;
    logic       vsync;
    logic       up;
    logic       down;
    logic       wave_we;
    logic [9:0] wave_index;
    logic [9:0] wave_data;
    logic       busy;
    logic       done;
    logic [9:0] p_vpos;

    playfield_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .mode       (mode),
        .start      (start),
        .vsync      (vsync),
        .up         (up),
        .down       (down),
        .wave_we    (wave_we),
        .wave_index (wave_index),
        .wave_data  (wave_data),
        .busy       (busy),
        .done       (done),
        .p_vpos     (p_vpos)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference profile straight from the sample formulas.
    function automatic int ref_wave(input int m, input int i);
        int t;
        case (m)
            1: return i % 768;
            2: begin
                t = i % 512;
                return (t < 256) ? t : 511 - t;
            end
            default: return 384;
        endcase
    endfunction

    // Player model: saturating +/-100 on isolated rising edges.
    int exp_p = 384;
    bit pu = 1'b1;
    bit pd = 1'b1;
    bit rand_btn = 1'b0;

    // Write scoreboard.
    int wi_q[$];
    int wd_q[$];
    int wc_q[$];
    int cyc = 0;
    int done_n = 0;
    int done_cyc = 0;

    task automatic step();
        bit ur, dr;
        if (rand_btn) begin
            up   = 1'($urandom_range(0, 1));
            down = 1'($urandom_range(0, 1));
        end
        if (!reset_n) begin
            exp_p = 384;
            pu = 1'b1;
            pd = 1'b1;
        end else begin
            ur = up && !pu;
            dr = down && !pd;
            if (ur && !dr) exp_p = (exp_p >= 100) ? exp_p - 100 : 0;
            else if (dr && !ur) exp_p = (exp_p + 100 > 767) ? 767 : exp_p + 100;
            pu = up;
            pd = down;
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
        chk("p_vpos", 32'(p_vpos), 32'(exp_p));
        if (wave_we) begin
            wi_q.push_back(int'(wave_index));
            wd_q.push_back(int'(wave_data));
            wc_q.push_back(cyc);
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
    endtask

    task automatic clear_sb();
        wi_q.delete();
        wd_q.delete();
        wc_q.delete();
        done_n = 0;
    endtask

    // DUT must be waiting for vsync with vsync low.
    task automatic run_fill(input int m);
        int n;
        int bad;
        int last;
        clear_sb();
        vsync = 1'b1;
        step();
        chk("fill_first_we", 32'(wave_we), 1);
        chk("fill_first_idx", 32'(wave_index), 0);
        vsync = 1'b0;
        n = 0;
        while (done_n == 0 && n < 1200) begin
            step();
            n++;
        end
        chk("fill_done_count", 32'(done_n), 1);
        chk("fill_len", 32'(wi_q.size()), 1024);
        bad = 0;
        foreach (wi_q[k]) begin
            if (wi_q[k] != k || wd_q[k] != ref_wave(m, k)) bad++;
        end
        chk("fill_bad_entries", 32'(bad), 0);
        if (wi_q.size() > 0) begin
            last = wi_q.size() - 1;
            chk("fill_contiguous", 32'(wc_q[last] - wc_q[0]), 1023);
            chk("done_after_last", 32'(done_cyc), 32'(wc_q[last] + 1));
        end
        step();
        chk("done_one_cycle", 32'(done), 0);
        chk("idle_not_busy", 32'(busy), 0);
    endtask

    int exp_up[5] = '{284, 184, 84, 0, 0};
    int exp_dn[9] = '{100, 200, 300, 400, 500, 600, 700, 767, 767};

    initial begin
        int m;
        int n;
        reset_n = 1'b0;
        mode    = 2'd1;
        start   = 1'b0;
        vsync   = 1'b1;
        up      = 1'b1;
        down    = 1'b1;
        repeat (3) step();
        chk("rst_we", 32'(wave_we), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_index", 32'(wave_index), 0);
        reset_n = 1'b1;

        // Levels held high through reset: no vsync or button edge.
        clear_sb();
        repeat (10) step();
        chk("rst_busy", 32'(busy), 1);
        chk("no_edge_after_rst", 32'(wi_q.size()), 0);
        vsync = 1'b0;
        up    = 1'b0;
        down  = 1'b0;
        repeat (2) step();
        run_fill(1);

        // Directed presses.
        for (int k = 0; k < 5; k++) begin
            up = 1'b1; step(); up = 1'b0; step();
            chk("up_press", 32'(p_vpos), 32'(exp_up[k]));
        end
        for (int k = 0; k < 9; k++) begin
            down = 1'b1; step(); down = 1'b0; step();
            chk("down_press", 32'(p_vpos), 32'(exp_dn[k]));
        end
        up = 1'b1; down = 1'b1; step();
        chk("both_rise", 32'(p_vpos), 767);
        up = 1'b0; down = 1'b0; step();
        up = 1'b1;
        repeat (1000) step();
        chk("held_up", 32'(p_vpos), 667);
        up = 1'b0; step();

        // start without vsync: busy forever, no writes.
        start = 1'b1; step(); start = 1'b0;
        clear_sb();
        repeat (50) step();
        chk("wait_vs_busy", 32'(busy), 1);
        chk("wait_vs_no_we", 32'(wi_q.size()), 0);
        start = 1'b1; step(); start = 1'b0; step();
        m = $urandom_range(0, 3);
        mode = 2'(m);
        repeat (3) step();
        run_fill(m);

        // Abort at write 500 by mode change.
        mode = 2'd0;
        repeat (3) step();
        start = 1'b1; step(); start = 1'b0; step();
        clear_sb();
        vsync = 1'b1; step(); vsync = 1'b0;
        n = 0;
        while (!(wave_we && wave_index == 10'd500) && n < 700) begin
            step();
            n++;
        end
        chk("abort_reached_500", 32'(wave_index), 500);
        mode = 2'd2;
        step();
        chk("abort_we_low", 32'(wave_we), 0);
        chk("abort_busy", 32'(busy), 1);
        chk("abort_writes", 32'(wi_q.size()), 501);
        repeat (5) step();
        chk("abort_no_done", 32'(done_n), 0);
        run_fill(2);
        if (wd_q.size() > 512) begin
            chk("tri_255", 32'(wd_q[255]), 255);
            chk("tri_256", 32'(wd_q[256]), 255);
            chk("tri_511", 32'(wd_q[511]), 0);
            chk("tri_512", 32'(wd_q[512]), 0);
        end

        // Random buttons, then concurrently with a fill.
        rand_btn = 1'b1;
        repeat (300) step();
        start = 1'b1; step(); start = 1'b0; step();
        run_fill(2);
        rand_btn = 1'b0;
        up = 1'b0; down = 1'b0;
        repeat (2) step();

        // Reset at index 300 with up held.
        start = 1'b1; step(); start = 1'b0; step();
        up = 1'b1; step();
        clear_sb();
        vsync = 1'b1; step(); vsync = 1'b0;
        n = 0;
        while (!(wave_we && wave_index == 10'd300) && n < 400) begin
            step();
            n++;
        end
        chk("rst_mid_reached_300", 32'(wave_index), 300);
        reset_n = 1'b0;
        step();
        chk("rst_mid_we", 32'(wave_we), 0);
        chk("rst_mid_p", 32'(p_vpos), 384);
        reset_n = 1'b1;
        repeat (20) step();
        chk("rst_mid_held_no_move", 32'(p_vpos), 384);
        chk("rst_mid_no_done", 32'(done_n), 0);
        up = 1'b0; step();
        up = 1'b1; step();
        chk("rst_mid_repress", 32'(p_vpos), 284);
        up = 1'b0; step();
        run_fill(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
